// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the encrypt and decrypt cores.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ARK,
    ST_ROUND,
    ST_FINAL
  } dec_state_e;

  // Exponent 254: a^254 is the multiplicative inverse in GF(2^8), and 0 maps to 0.
  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);  return gf_mul(a, 8'h09); endfunction
  function automatic logic [7:0] gf_mul11(input logic [7:0] a); return gf_mul(a, 8'h0b); endfunction
  function automatic logic [7:0] gf_mul13(input logic [7:0] a); return gf_mul(a, 8'h0d); endfunction
  function automatic logic [7:0] gf_mul14(input logic [7:0] a); return gf_mul(a, 8'h0e); endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box computed as field inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse affine map first, then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte idx of a column-major state; byte 0 sits in bits [127:120].
  function automatic logic [7:0] st_byte(input logic [127:0] s, input int idx);
    return s[127-8*idx -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// Request/result bus of the AES-128 decrypt core.
interface aes_decrypt_core_if;
  import aes_pkg::*;

  logic               start;
  logic [BLOCK_W-1:0] cipher_text;
  logic [BLOCK_W-1:0] cipher_key;
  logic               ready;
  logic               done;
  logic [BLOCK_W-1:0] plain_text;

  modport master (
    output start, cipher_text, cipher_key,
    input  ready, done, plain_text
  );

  modport slave (
    input  start, cipher_text, cipher_key,
    output ready, done, plain_text
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         is_final_i,
  output logic [127:0] state_o
);

  // InvShiftRows + InvSubBytes + AddRoundKey per column, then optional InvMixColumns
  always_comb begin
    logic [7:0] b [4];
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        b[r] = inv_sbox(st_byte(state_i, 4*((c - r + 4) % 4) + r)) ^ st_byte(rk_i, 4*c + r);
      end
      if (is_final_i) begin
        state_o[127-32*c -: 32] = {b[0], b[1], b[2], b[3]};
      end else begin
        state_o[127-32*c -: 32] = {
          gf_mul14(b[0]) ^ gf_mul11(b[1]) ^ gf_mul13(b[2]) ^ gf_mul9(b[3]),
          gf_mul9(b[0])  ^ gf_mul14(b[1]) ^ gf_mul11(b[2]) ^ gf_mul13(b[3]),
          gf_mul13(b[0]) ^ gf_mul9(b[1])  ^ gf_mul14(b[2]) ^ gf_mul11(b[3]),
          gf_mul11(b[0]) ^ gf_mul13(b[1]) ^ gf_mul9(b[2])  ^ gf_mul14(b[3])
        };
      end
    end
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key schedule to rk10, then
// one inverse round per clock while stepping the key schedule backwards.
module aes_decrypt_core
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rstn,
  aes_decrypt_core_if.slave bus
);

  localparam logic [3:0] NR4 = 4'(NR);

  dec_state_e   fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic [127:0] round_out;

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one schedule step: recover the older words first, w0 last.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  aes_inv_round u_inv_round (
    .state_i    (st_q),
    .rk_i       (key_q),
    .is_final_i (fsm_q == ST_FINAL),
    .state_o    (round_out)
  );

  // Controller: next state, round counter and datapath register updates
  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    st_d   = st_q;
    key_d  = key_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          st_d  = bus.cipher_text;
          key_d = bus.cipher_key;
          rnd_d = 4'd1;
          fsm_d = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        key_d = key_fwd(key_q, rcon(rnd_q));
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == NR4) fsm_d = ST_ARK;
      end
      ST_ARK: begin
        st_d  = st_q ^ key_q;
        key_d = key_inv(key_q, rcon(NR4));
        rnd_d = NR4 - 4'd1;
        fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        st_d  = round_out;
        key_d = key_inv(key_q, rcon(rnd_q));
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        pt_d   = round_out;
        done_d = 1'b1;
        fsm_d  = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm_q  <= ST_IDLE;
      rnd_q  <= '0;
      st_q   <= '0;
      key_q  <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      st_q   <= st_d;
      key_q  <= key_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign bus.ready      = (fsm_q == ST_IDLE);
  assign bus.done       = done_q;
  assign bus.plain_text = pt_q;

endmodule

// File: doc/aes_decrypt_core.md
Name: aes_decrypt_core

Overview:
Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decrypt counterpart of the team's encrypt datapath. It uses one combinational inverse round per clock and has its own built-in controller FSM. The key is supplied as the cipher key (round key 0). The block first runs the forward key schedule to round key 10, then walks the schedule backwards on the fly during decryption. It sits beside the encrypt core under the AES top and shares the S-box and Rcon constants with it.

Parameters:
NR, 10, number of rounds (fixed for AES-128; not overridable in this revision)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  request; sampled only when ready=1
cipher_text  in  128  ciphertext block; captured on the accepting edge
cipher_key  in  128  AES-128 cipher key; captured on the accepting edge
ready  out  1  high in IDLE
done  out  1  one-cycle pulse; plain_text valid from this cycle
plain_text  out  128  result; held until the next done

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, round counter=0, state/key registers=0, plain_text=0, done=0. ready=1 after reset.
- Reset mid-operation aborts immediately, with the same values as above. No done is produced for the aborted block.
- Byte order: bit [127:120] is byte 0; column-major state as in FIPS-197.
- FSM states:
  - IDLE: start=1 at edge E0 loads the state register from cipher_text and the key register from cipher_key, sets rnd=1, and goes to KEYEXP.
  - KEYEXP: each edge key <= forward KeyExpansion(key, Rcon(rnd)) and rnd++. After edge E10 the key register holds rk10; go to ARK.
  - ARK (edge E11): state <= state ^ rk10. Key steps back to rk9 using Rcon(10). rnd=9. Go to ROUND.
  - ROUND: each edge E12..E20 computes state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_rnd). Key steps to rk_(rnd-1) using Rcon(rnd). rnd--. When rnd=0, go to FINAL.
  - FINAL (edge E21): plain_text <= InvSubBytes(InvShiftRows(state)) ^ rk0. done=1 for the following cycle. Go to IDLE.
- Latency: done is high in the cycle after E21, i.e. 21 clocks after the accepting edge.
- Throughput: one block per 22 cycles when start is held high.
- Inverse key step from rk_i (words w0..w3):
  - w3'=w3^w2
  - w2'=w2^w1
  - w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^Rcon(i)
- Rcon(1..10)=01,02,04,08,10,20,40,80,1b,36 in the MSB byte. GF(2^8) polynomial is 0x11b.
- ready=1 only in IDLE. start while busy is ignored and not queued. cipher_text and cipher_key may change freely after the accepting edge.
- Simultaneous events: the done cycle is an IDLE cycle. start in that cycle is accepted, and plain_text stays stable until the next FINAL.
- plain_text updates only at FINAL and never shows intermediate state.

Decomposition:
- Shared package aes_pkg contains:
  - NR
  - Rcon table
  - forward S-box and inverse S-box functions
  - xtime and gf_mul helpers for 9/11/13/14
  - state index helpers
  The encrypt core's sub-blocks migrate to this package later.
- One sub-module: aes_inv_round. It is combinational and has inputs state, rk, and is_final (skip InvMixColumns). The FSM, counter and both key-step functions stay in aes_decrypt_core.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff. done occurs exactly 21 cycles after the accepting edge. Internal key equals 13111d7fe3944a17f307a78b4d2b30c5 after E10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Busy rejection: pulse start with a garbage ct/key at cycle 5 of the C.1 run -> C.1 result unchanged, and exactly one done.
- Back-to-back: hold start=1 with C.1 then App. B inputs -> both results correct, done pulses 22 cycles apart, and plain_text stable between them.
- Reset mid-run: rstn=0 at cycle 8 -> next cycle ready=1, plain_text=0, no done. A subsequent C.1 run is correct.
- Random: 1000 key/ct pairs against a reference model -> all match, and every done is a single-cycle pulse.
